// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline control unit for the 5-stage core.
//
// Generates the per-stage stall/bubble controls for the IF/ID, ID/EX,
// EX/MEM and MEM/WB registers plus the PC hold. Hazards are resolved in
// the same cycle they are presented, in fixed priority:
//   data-memory wait > EX redirect > load-use > instruction-fetch wait.
// A watchdog bounds consecutive data-memory wait cycles to WAIT_MAX. After
// that many cycles it forces the pipe to advance and sets a sticky timeout
// flag. Two wrapping counters track stalled cycles and accepted redirects.
//
// Ports:
//   clk, rst          core clock (rising edge), synchronous active-high reset
//   rs1_id, rs2_id    source indices of the ID instruction
//   use_rs1_id/rs2_id ID instruction actually reads rs1/rs2
//   rd_ex             destination index of the EX instruction
//   mem_read_ex       EX instruction is a load
//   redirect_ex       taken branch/jal/jalr resolved in EX
//   dmem_req_mem      MEM instruction is accessing data memory
//   dmem_ack          data memory completes the access this cycle
//   imem_ready        fetch data valid this cycle
//   pc_stall          hold the PC
//   stall_*/bubble_*  IF/ID (id), ID/EX (ex), EX/MEM (mem), MEM/WB (wb) controls
//   dmem_timeout      sticky watchdog flag, cleared only by rst
//   stall_cycles      count of cycles with pc_stall=1
//   flush_count       count of accepted redirects
module hazard_ctrl #(
  parameter int WAIT_MAX = 255,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic             use_rs1_id,
  input  logic             use_rs2_id,
  input  logic [4:0]       rd_ex,
  input  logic             mem_read_ex,
  input  logic             redirect_ex,
  input  logic             dmem_req_mem,
  input  logic             dmem_ack,
  input  logic             imem_ready,
  output logic             pc_stall,
  output logic             stall_id,
  output logic             bubble_id,
  output logic             stall_ex,
  output logic             bubble_ex,
  output logic             stall_mem,
  output logic             bubble_mem,
  output logic             stall_wb,
  output logic             bubble_wb,
  output logic             dmem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int WC_W = $clog2(WAIT_MAX + 1);

  logic [WC_W-1:0]  wait_cnt_r;
  logic             dmem_timeout_r;
  logic [CNT_W-1:0] stall_cycles_r;
  logic [CNT_W-1:0] flush_count_r;

  logic             dmem_pending_s;
  logic             wait_at_max_s;
  logic             dwait_s;
  logic             load_use_s;
  logic             redirect_win_s;

  // Hazard detection terms.
  always_comb begin
    dmem_pending_s = dmem_req_mem & ~dmem_ack;
    wait_at_max_s  = (wait_cnt_r == WC_W'(WAIT_MAX));
    // At the watchdog limit the wait is dropped so the pipe can advance.
    dwait_s        = dmem_pending_s & ~wait_at_max_s;
    // x0 is never a real dependency, so a load to rd=0 cannot cause a stall.
    load_use_s     = mem_read_ex & (rd_ex != 5'd0) &
                     ((use_rs1_id & (rs1_id == rd_ex)) |
                      (use_rs2_id & (rs2_id == rd_ex)));
    redirect_win_s = ~rst & ~dwait_s & redirect_ex;
  end

  // Prioritised stall/bubble decode.
  always_comb begin
    pc_stall   = 1'b0;
    stall_id   = 1'b0;
    bubble_id  = 1'b0;
    stall_ex   = 1'b0;
    bubble_ex  = 1'b0;
    stall_mem  = 1'b0;
    bubble_mem = 1'b0;
    stall_wb   = 1'b0;
    bubble_wb  = 1'b0;
    if (rst) begin
      bubble_id  = 1'b1;
      bubble_ex  = 1'b1;
      bubble_mem = 1'b1;
      bubble_wb  = 1'b1;
    end else if (dwait_s) begin
      // Freeze everything up to MEM. EX keeps its instruction, so a pending
      // redirect shows up again once the wait ends.
      pc_stall   = 1'b1;
      stall_id   = 1'b1;
      stall_ex   = 1'b1;
      stall_mem  = 1'b1;
      bubble_wb  = 1'b1;
    end else if (redirect_ex) begin
      // IF/ID hold wrong-path instructions. Squash them and let the PC load
      // the target.
      bubble_id  = 1'b1;
      bubble_ex  = 1'b1;
    end else if (load_use_s) begin
      pc_stall   = 1'b1;
      stall_id   = 1'b1;
      bubble_ex  = 1'b1;
    end else if (!imem_ready) begin
      pc_stall   = 1'b1;
      bubble_id  = 1'b1;
    end else begin
      pc_stall   = 1'b0;
    end
  end

  // Watchdog, sticky timeout flag and performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_r     <= '0;
      dmem_timeout_r <= 1'b0;
      stall_cycles_r <= '0;
      flush_count_r  <= '0;
    end else begin
      if (dmem_pending_s) begin
        if (wait_at_max_s) begin
          wait_cnt_r     <= '0;
          dmem_timeout_r <= 1'b1;
        end else begin
          wait_cnt_r     <= wait_cnt_r + WC_W'(1);
        end
      end else begin
        wait_cnt_r <= '0;
      end
      if (pc_stall) begin
        stall_cycles_r <= stall_cycles_r + CNT_W'(1);
      end
      if (redirect_win_s) begin
        flush_count_r <= flush_count_r + CNT_W'(1);
      end
    end
  end

  assign dmem_timeout = dmem_timeout_r;
  assign stall_cycles = stall_cycles_r;
  assign flush_count  = flush_count_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl -- directed self-checking bench for hazard_ctrl.
// The controls are packed as
// {pc_stall, stall_id, bubble_id, stall_ex, bubble_ex, stall_mem, bubble_mem,
// stall_wb, bubble_wb}. They are checked on the falling edge. Counters and
// the timeout flag are checked just after the rising edge.
module tb_hazard_ctrl;

  localparam int CNT_W = 32;

  localparam logic [8:0] C_IDLE  = 9'b000000000;
  localparam logic [8:0] C_RST   = 9'b001010101;
  localparam logic [8:0] C_DWAIT = 9'b110101001;
  localparam logic [8:0] C_REDIR = 9'b001010000;
  localparam logic [8:0] C_LU    = 9'b110010000;
  localparam logic [8:0] C_FETCH = 9'b101000000;

  logic             clk;
  logic             rst;
  logic [4:0]       rs1_id, rs2_id, rd_ex;
  logic             use_rs1_id, use_rs2_id, mem_read_ex, redirect_ex;
  logic             dmem_req_mem, dmem_ack, imem_ready;
  logic             pc_stall, stall_id, bubble_id, stall_ex, bubble_ex;
  logic             stall_mem, bubble_mem, stall_wb, bubble_wb, dmem_timeout;
  logic [CNT_W-1:0] stall_cycles, flush_count;
  logic [8:0]       ctl_s;

  int n_cmp = 0;
  int n_err = 0;

  hazard_ctrl #(.WAIT_MAX(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .rs1_id(rs1_id), .rs2_id(rs2_id),
    .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id),
    .rd_ex(rd_ex), .mem_read_ex(mem_read_ex), .redirect_ex(redirect_ex),
    .dmem_req_mem(dmem_req_mem), .dmem_ack(dmem_ack), .imem_ready(imem_ready),
    .pc_stall(pc_stall),
    .stall_id(stall_id), .bubble_id(bubble_id),
    .stall_ex(stall_ex), .bubble_ex(bubble_ex),
    .stall_mem(stall_mem), .bubble_mem(bubble_mem),
    .stall_wb(stall_wb), .bubble_wb(bubble_wb),
    .dmem_timeout(dmem_timeout),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  assign ctl_s = {pc_stall, stall_id, bubble_id, stall_ex, bubble_ex,
                  stall_mem, bubble_mem, stall_wb, bubble_wb};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    rs1_id = 5'd0; rs2_id = 5'd0; rd_ex = 5'd0;
    use_rs1_id = 1'b0; use_rs2_id = 1'b0; mem_read_ex = 1'b0;
    redirect_ex = 1'b0; dmem_req_mem = 1'b0; dmem_ack = 1'b0;
    imem_ready = 1'b1;
  endtask

  // Check the controls for the current inputs, then step one clock.
  task automatic cyc(input string tag, input logic [8:0] exp);
    @(negedge clk);
    check_val(tag, {23'd0, ctl_s}, {23'd0, exp});
    @(posedge clk);
    #1;
  endtask

  task automatic check_regs(input string tag, input logic [31:0] sc,
                            input logic [31:0] fc, input logic to);
    check_val({tag, "_stall_cycles"}, stall_cycles, sc);
    check_val({tag, "_flush_count"}, flush_count, fc);
    check_val({tag, "_timeout"}, {31'd0, dmem_timeout}, {31'd0, to});
  endtask

  initial begin
    // Reset asserted during an active data-memory wait.
    idle_in();
    rst = 1'b1;
    dmem_req_mem = 1'b1;
    cyc("rst_ctl", C_RST);
    check_regs("rst", 32'd0, 32'd0, 1'b0);
    rst = 1'b0;
    idle_in();
    cyc("idle", C_IDLE);

    // Load-use on rs1: exactly one stall cycle.
    mem_read_ex = 1'b1; rd_ex = 5'd5; rs1_id = 5'd5; use_rs1_id = 1'b1;
    cyc("lu_rs1", C_LU);
    idle_in();
    cyc("lu_after", C_IDLE);
    check_regs("lu", 32'd1, 32'd0, 1'b0);

    // Load to x0 never stalls.
    mem_read_ex = 1'b1; rd_ex = 5'd0; rs1_id = 5'd0; use_rs1_id = 1'b1;
    cyc("lu_x0", C_IDLE);
    // rs1 matches but is not used, so no stall.
    mem_read_ex = 1'b1; rd_ex = 5'd7; rs1_id = 5'd7; use_rs1_id = 1'b0;
    cyc("lu_unused", C_IDLE);
    // Load-use on rs2.
    use_rs2_id = 1'b1; rs2_id = 5'd7;
    cyc("lu_rs2", C_LU);
    idle_in();
    check_regs("lu2", 32'd2, 32'd0, 1'b0);

    // Redirect + load-use + fetch wait in the same cycle: the redirect wins.
    redirect_ex = 1'b1; mem_read_ex = 1'b1; rd_ex = 5'd5; rs1_id = 5'd5;
    use_rs1_id = 1'b1; imem_ready = 1'b0;
    cyc("redir_all", C_REDIR);
    idle_in();
    check_regs("redir", 32'd2, 32'd1, 1'b0);

    // Data-memory wait for 3 cycles with a pending redirect, then ack.
    dmem_req_mem = 1'b1; dmem_ack = 1'b0; redirect_ex = 1'b1;
    for (int i = 0; i < 3; i++) cyc("dwait", C_DWAIT);
    dmem_ack = 1'b1;
    cyc("dwait_ack", C_REDIR);
    idle_in();
    cyc("dwait_done", C_IDLE);
    check_regs("dwait", 32'd5, 32'd2, 1'b0);

    // Fetch wait for 2 cycles.
    imem_ready = 1'b0;
    cyc("fetch0", C_FETCH);
    cyc("fetch1", C_FETCH);
    imem_ready = 1'b1;
    cyc("fetch_done", C_IDLE);
    check_regs("fetch", 32'd7, 32'd2, 1'b0);

    // Watchdog: the access is never acked. Stalls occur for wait_cnt 0..3
    // and the fifth cycle is released.
    dmem_req_mem = 1'b1; dmem_ack = 1'b0;
    for (int i = 0; i < 4; i++) cyc("wd_wait", C_DWAIT);
    check_val("wd_no_timeout_yet", {31'd0, dmem_timeout}, 32'd0);
    cyc("wd_release", C_IDLE);
    check_regs("wd_rel", 32'd11, 32'd2, 1'b1);
    // The counter restarted, so a still-pending access stalls again.
    cyc("wd_restart", C_DWAIT);
    idle_in();
    cyc("wd_idle", C_IDLE);
    cyc("wd_idle2", C_IDLE);
    check_regs("wd_sticky", 32'd12, 32'd2, 1'b1);

    // Reset in the middle of a wait clears everything, including the timeout.
    dmem_req_mem = 1'b1; dmem_ack = 1'b0;
    cyc("wd_wait2", C_DWAIT);
    rst = 1'b1;
    cyc("rst_mid_ctl", C_RST);
    check_regs("rst_mid", 32'd0, 32'd0, 1'b0);
    rst = 1'b0;
    cyc("post_rst_wait", C_DWAIT);
    idle_in();
    cyc("post_rst_idle", C_IDLE);
    check_regs("post_rst", 32'd1, 32'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline control unit for the 5-stage core.
- Produces the per-stage stall/bubble controls for the IF/ID, ID/EX, EX/MEM and MEM/WB PipeDff-based registers, plus the PC hold.
- Resolves data-memory wait states, branch/jump redirects, load-use hazards and instruction-fetch wait states in a fixed priority.
- Keeps a data-memory wait watchdog and performance counters.

Parameters:
- WAIT_MAX, 255, maximum consecutive data-memory wait cycles before a forced release and timeout flag.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- rs1_id  in  5  rs1 index of the instruction in ID.
- rs2_id  in  5  rs2 index of the instruction in ID.
- use_rs1_id  in  1  ID instruction reads rs1.
- use_rs2_id  in  1  ID instruction reads rs2.
- rd_ex  in  5  destination index of the instruction in EX.
- mem_read_ex  in  1  EX instruction is a load.
- redirect_ex  in  1  taken branch/jal/jalr resolved in EX.
- dmem_req_mem  in  1  MEM instruction is accessing data memory.
- dmem_ack  in  1  data memory completes the access this cycle.
- imem_ready  in  1  fetch data valid this cycle.
- pc_stall  out  1  hold the PC.
- stall_id, bubble_id  out  1 each  IF/ID register control.
- stall_ex, bubble_ex  out  1 each  ID/EX register control.
- stall_mem, bubble_mem  out  1 each  EX/MEM register control.
- stall_wb, bubble_wb  out  1 each  MEM/WB register control.
- dmem_timeout  out  1  sticky watchdog flag.
- stall_cycles  out  CNT_W  count of cycles with pc_stall=1.
- flush_count  out  CNT_W  count of accepted redirects.

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high.
- Control outputs are combinational from inputs and state. Counters, wait_cnt (clog2(WAIT_MAX+1) bits) and dmem_timeout are registered.
- While rst=1:
  - all stall_* and pc_stall are 0.
  - bubble_id/ex/mem/wb are 1, flushing the pipe.
  - On the clock edge, counters, wait_cnt and dmem_timeout clear to 0.
- A stage's stall and bubble are never both 1. stall_wb is always 0.
- Definitions:
  - dwait = dmem_req_mem & ~dmem_ack & (wait_cnt != WAIT_MAX).
  - load_use = mem_read_ex & (rd_ex != 0) & ((use_rs1_id & rs1_id == rd_ex) | (use_rs2_id & rs2_id == rd_ex)).
- Priority, highest first (all unlisted controls are 0):
  1. dwait: pc_stall, stall_id, stall_ex, stall_mem = 1; bubble_wb = 1. Redirect, load-use and fetch are ignored this cycle; the EX instruction holds, so redirect_ex re-presents on release.
  2. redirect_ex: bubble_id = 1, bubble_ex = 1; pc_stall = 0 so the PC takes the target. Load-use and fetch wait are ignored because ID/IF hold wrong-path instructions.
  3. load_use: pc_stall = 1, stall_id = 1, bubble_ex = 1. Exactly one bubble; the next cycle has the load in MEM, so load_use = 0.
  4. ~imem_ready: pc_stall = 1, bubble_id = 1.
  5. Otherwise: all controls are 0.
- Watchdog:
  - wait_cnt increments each cycle with dmem_req_mem & ~dmem_ack.
  - wait_cnt clears on dmem_ack, on ~dmem_req_mem, or when the forced release occurs.
  - When wait_cnt == WAIT_MAX and the access is still unacked, dwait = 0 (forced release, the pipe advances). dmem_timeout sets and stays set until rst.
- Counters:
  - stall_cycles += 1 on every cycle with pc_stall = 1 and rst = 0.
  - flush_count += 1 on every cycle where priority 2 is the winning rule.
  - Both counters wrap modulo 2^CNT_W.
- Latency: zero-cycle response; the hazard is resolved in the same cycle it is presented.
- Reset mid-wait: rst overrides dwait immediately; wait_cnt clears on the edge.

Test Plan:
- Load-use: mem_read_ex=1, rd_ex=5, rs1_id=5, use_rs1_id=1 for one cycle -> pc_stall=stall_id=bubble_ex=1 for exactly 1 cycle; stall_cycles=1. Repeat with rd_ex=0 -> no stall.
- Redirect plus load-use plus ~imem_ready, all same cycle -> bubble_id=bubble_ex=1, pc_stall=0, flush_count increments by 1.
- Dmem wait: dmem_req_mem=1 with dmem_ack low for 3 cycles, then high -> 3 cycles of stall_id/ex/mem=1, bubble_wb=1, then all controls 0. redirect_ex held high throughout is honoured only on the ack cycle.
- Watchdog, WAIT_MAX=4, ack never asserted -> stall on cycles with wait_cnt 0..3; cycle 5 releases (stalls 0); dmem_timeout=1 from then and persists until rst.
- Fetch wait: imem_ready=0 for 2 cycles, no other hazard -> pc_stall=bubble_id=1 for 2 cycles; stall_cycles=2.
- Reset: rst=1 during an active dwait -> all bubbles 1, all stalls 0; after the edge, counters, wait_cnt and dmem_timeout read 0.
